// File: rtl/seq_divider_8_by_4_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package calc_div_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must be able to count up to DIVIDEND_W.
  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_8_by_4_if.sv
// start/busy/done handshake and operand/result bus between ALU control and divider.
interface seq_divider_8_by_4_if
  import calc_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_8_by_4_div_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_restore_step #(
  parameter int W = 4
) (
  input  logic [W:0]   r_i,
  input  logic         bit_i,
  input  logic [W-1:0] v_i,
  output logic [W:0]   r_o,
  output logic         q_o
);

  localparam int RW = W + 1;

  // r_i[W] is always 0 because the partial remainder stays below V; keeping it
  // in the trial value costs nothing and keeps the comparison exact.
  logic [W+1:0] trial;

  assign trial = {r_i, bit_i};
  assign q_o   = (trial >= {2'b00, v_i});
  assign r_o   = q_o ? RW'(trial - {2'b00, v_i}) : RW'(trial);

endmodule

// File: rtl/seq_divider_8_by_4.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider_8_by_4
  import calc_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_8_by_4_if.slave bus
);

  localparam int                CNT_W     = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] d_q, d_d;
  logic [DIVISOR_W-1:0]  v_q, v_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_r;
  logic                  step_q;

  div_restore_step #(
    .W (DIVISOR_W)
  ) u_step (
    .r_i   (r_q),
    .bit_i (d_q[DIVIDEND_W-1]),
    .v_i   (v_q),
    .r_o   (step_r),
    .q_o   (step_q)
  );

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no branch can infer a latch.
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d   = bus.dividend;
          v_d   = bus.divisor;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        d_d   = {d_q[DIVIDEND_W-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          quo_d   = {d_q[DIVIDEND_W-2:0], step_q};
          rem_d   = step_r[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears every register, including the datapath, so an aborted run leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
